// File: rtl/dac_sample_feeder.sv
// DAC sample feeder: buffers producer samples in a small FIFO and
// releases one sample per DAC frame once the buffer has been primed.
module dac_sample_feeder #(
    parameter int          DEPTH      = 8,
    parameter int          FRAME_LEN  = 33,
    parameter int          PRIME_LVL  = 4,
    parameter logic [11:0] RESET_CODE = 12'h800
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [11:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     clr_underrun,
    output logic [11:0]              dac_data,
    output logic                     frame_start,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun,
    output logic                     playing
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] PRIME_L  = LW'(PRIME_LVL);

    typedef enum logic {
        S_PRIME,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [11:0]     dac_q, dac_d;
    logic            fs_q, fs_d;
    logic            und_q, und_d;
    logic [11:0]     mem_q [DEPTH];

    logic tick;
    logic push;
    logic run_tick;
    logic pop;
    logic starve;

    assign tick     = (frame_cnt_q == LAST_CNT);
    assign in_ready = (level_q < FULL_LVL);
    assign push     = in_valid && in_ready;
    // A frame only plays out while enabled in RUN; enable low freezes output.
    assign run_tick = tick && enable && (state_q == S_RUN);
    assign pop      = run_tick && (level_q != '0);
    assign starve   = run_tick && (level_q == '0);

    // Datapath next-state: frame counter, FIFO pointers, level and outputs.
    always_comb begin
        frame_cnt_d = tick ? '0 : frame_cnt_q + CW'(1);
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d     = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        dac_d = pop ? mem_q[rd_ptr_q] : dac_q;
        fs_d  = run_tick;
        und_d = und_q;
        if (starve) begin
            und_d = 1'b1;
        end else if (clr_underrun) begin
            und_d = 1'b0;
        end
    end

    // Playback FSM next-state: prime until enough samples, then run.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_PRIME;
        end else if (state_q == S_PRIME && tick && level_q >= PRIME_L) begin
            state_d = S_RUN;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_PRIME;
            frame_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            dac_q       <= RESET_CODE;
            fs_q        <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            dac_q       <= dac_d;
            fs_q        <= fs_d;
            und_q       <= und_d;
        end
    end

    // Sample storage; contents are don't-care until pointers cover them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign dac_data    = dac_q;
    assign frame_start = fs_q;
    assign level       = level_q;
    assign underrun    = und_q;
    assign playing     = (state_q == S_RUN);

endmodule
